// File: rtl/fpu_norm_pkg.sv
// Shared types for the FPU normalisation pipeline.
// The structs are sized by the NORM_* defaults, so retarget widths here rather than on the module.
package fpu_norm_pkg;

  localparam int NORM_MAN_W = 24;
  localparam int NORM_EXP_W = 8;
  localparam int NORM_TAG_W = 4;
  localparam int NORM_CNT_W = $clog2(NORM_MAN_W);

  typedef struct packed {
    logic [NORM_MAN_W-1:0] man;
    logic [NORM_EXP_W-1:0] exp;
    logic [NORM_TAG_W-1:0] tag;
    logic [NORM_CNT_W-1:0] cnt;
    logic                  zero;
  } norm_s1_t;

  typedef struct packed {
    logic [NORM_MAN_W-1:0] man;
    logic [NORM_EXP_W-1:0] exp;
    logic [NORM_TAG_W-1:0] tag;
    logic [NORM_CNT_W-1:0] shamt;
    logic                  zero;
    logic                  tiny;
  } norm_res_t;

endpackage

// File: rtl/lzc.sv
// Leading (MODE=1) or trailing (MODE=0) zero counter.
// An all-zero input reports cnt_o=0 with empty_o set.
module lzc #(
  parameter  int WIDTH = 24,
  parameter  int MODE  = 1,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Later loop iterations win, so the scan order picks the set bit nearest the counted end.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE == 1) begin
        if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage valid/ready mantissa normaliser: stage 1 counts leading zeros,
// stage 2 shifts left and lowers the exponent, clamping at exponent 0.
module fp_norm_pipe
  import fpu_norm_pkg::*;
#(
  parameter  int MAN_W = NORM_MAN_W,
  parameter  int EXP_W = NORM_EXP_W,
  parameter  int TAG_W = NORM_TAG_W,
  localparam int CNT_W = $clog2(MAN_W)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [MAN_W-1:0] in_man_i,
  input  logic [EXP_W-1:0] in_exp_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [MAN_W-1:0] out_man_o,
  output logic [EXP_W-1:0] out_exp_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [CNT_W-1:0] out_shamt_o,
  output logic             out_zero_o,
  output logic             out_tiny_o
);

  localparam int CMP_W = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  logic             s1_valid, s2_valid;
  logic             s1_ready, s2_ready;
  logic             in_fire, s1_fire;
  logic [CNT_W-1:0] lz_cnt;
  logic             lz_zero;
  norm_s1_t         s1_d, s1_q;
  norm_res_t        res_d, res_q;
  logic [CMP_W-1:0] cnt_ext, exp_ext, shamt_ext;

  assign s2_ready   = ~s2_valid | out_ready_i;
  assign s1_ready   = ~s1_valid | s2_ready;
  assign in_ready_o = s1_ready;
  assign in_fire    = in_valid_i & s1_ready;
  assign s1_fire    = s1_valid & s2_ready;

  lzc #(
    .WIDTH(MAN_W),
    .MODE (1)
  ) u_lzc (
    .in_i   (in_man_i),
    .cnt_o  (lz_cnt),
    .empty_o(lz_zero)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.man  = in_man_i;
    s1_d.exp  = in_exp_i;
    s1_d.tag  = in_tag_i;
    s1_d.cnt  = lz_cnt;
    s1_d.zero = lz_zero;
  end

  // Shift is limited by the exponent so the result never goes below exponent 0.
  always_comb begin
    cnt_ext   = CMP_W'(s1_q.cnt);
    exp_ext   = CMP_W'(s1_q.exp);
    shamt_ext = (cnt_ext > exp_ext) ? exp_ext : cnt_ext;
    res_d      = '0;
    res_d.tag  = s1_q.tag;
    res_d.zero = s1_q.zero;
    if (!s1_q.zero) begin
      res_d.shamt = CNT_W'(shamt_ext);
      res_d.man   = s1_q.man << shamt_ext;
      res_d.exp   = EXP_W'(exp_ext - shamt_ext);
      res_d.tiny  = cnt_ext > exp_ext;
    end
  end

  // Flush outranks every transfer and empties both stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_fire | (s1_valid & ~s2_ready);
      s2_valid <= s1_fire | (s2_valid & ~out_ready_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
    end else if (in_fire && !flush_i) begin
      s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (s1_fire && !flush_i) begin
      res_q <= res_d;
    end
  end

  assign out_valid_o = s2_valid;
  assign out_man_o   = res_q.man;
  assign out_exp_o   = res_q.exp;
  assign out_tag_o   = res_q.tag;
  assign out_shamt_o = res_q.shamt;
  assign out_zero_o  = res_q.zero;
  assign out_tiny_o  = res_q.tiny;

endmodule
